div_ctrl: RTL and testbench

Sequencing controller for the multi-cycle 32-bit divider in the EX stage. It accepts a DIV/DIVU request from EX and latches the operands. It drives the divider's start/annul/operand inputs for the whole operation and requests a pipeline stall until the result returns. It then writes the result to HI/LO, annuls the divider on a pipeline flush, and aborts with an error pulse if the divider exceeds a cycle budget.

---
 rtl/div_ctrl_if.sv | 35 +++
 rtl/div_ctrl.sv | 127 ++++++++++++
 tb/tb_div_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/div_ctrl_if.sv
// Bundle between the EX-stage divide controller, the pipeline and the multi-cycle divider.
// The master modport is the controller's view; the slave modport is its environment.
interface div_ctrl_if;
    logic        ex_div_i;
    logic        ex_signed_i;
    logic [31:0] ex_op1_i;
    logic [31:0] ex_op2_i;
    logic        flush_i;
    logic        div_signed_o;
    logic [31:0] div_op1_o;
    logic [31:0] div_op2_o;
    logic        div_start_o;
    logic        div_annul_o;
    logic [63:0] div_result_i;
    logic        div_ready_i;
    logic        stallreq_o;
    logic        hilo_we_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        err_o;

    modport master (
        input  ex_div_i, ex_signed_i, ex_op1_i, ex_op2_i, flush_i,
        input  div_result_i, div_ready_i,
        output div_signed_o, div_op1_o, div_op2_o, div_start_o, div_annul_o,
        output stallreq_o, hilo_we_o, hi_o, lo_o, err_o
    );

    modport slave (
        output ex_div_i, ex_signed_i, ex_op1_i, ex_op2_i, flush_i,
        output div_result_i, div_ready_i,
        input  div_signed_o, div_op1_o, div_op2_o, div_start_o, div_annul_o,
        input  stallreq_o, hilo_we_o, hi_o, lo_o, err_o
    );
endinterface

// File: rtl/div_ctrl.sv
// Sequencing controller for the multi-cycle 32-bit divider: start/hold, HI/LO writeback,
// flush annul and a cycle-budget timeout abort.
module div_ctrl #(
    parameter int TIMEOUT = 40
) (
    input  logic       clk,
    input  logic       rst,
    div_ctrl_if.master bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE, ABORT} state_t;

    localparam logic [5:0] LAST_CNT = 6'(TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [5:0]  cnt, cnt_nxt;
    logic        signed_q, signed_nxt;
    logic [31:0] op1_q, op1_nxt;
    logic [31:0] op2_q, op2_nxt;
    logic        start_q, start_nxt;
    logic        annul_q, annul_nxt;
    logic        we_q, we_nxt;
    logic        err_q, err_nxt;
    logic [31:0] hi_q, hi_nxt;
    logic [31:0] lo_q, lo_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            signed_q <= 1'b0;
            op1_q    <= '0;
            op2_q    <= '0;
            start_q  <= 1'b0;
            annul_q  <= 1'b0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            signed_q <= signed_nxt;
            op1_q    <= op1_nxt;
            op2_q    <= op2_nxt;
            start_q  <= start_nxt;
            annul_q  <= annul_nxt;
            we_q     <= we_nxt;
            err_q    <= err_nxt;
            hi_q     <= hi_nxt;
            lo_q     <= lo_nxt;
        end
    end

    // Pulse outputs default low; operands and HI/LO hold unless explicitly loaded.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        signed_nxt = signed_q;
        op1_nxt    = op1_q;
        op2_nxt    = op2_q;
        start_nxt  = start_q;
        annul_nxt  = 1'b0;
        we_nxt     = 1'b0;
        err_nxt    = 1'b0;
        hi_nxt     = hi_q;
        lo_nxt     = lo_q;

        case (state)
            IDLE: begin
                start_nxt = 1'b0;
                if (bus.ex_div_i && !bus.flush_i) begin
                    signed_nxt = bus.ex_signed_i;
                    op1_nxt    = bus.ex_op1_i;
                    op2_nxt    = bus.ex_op2_i;
                    start_nxt  = 1'b1;
                    cnt_nxt    = '0;
                    state_nxt  = RUN;
                end
            end
            RUN: begin
                if (bus.flush_i) begin
                    start_nxt = 1'b0;
                    annul_nxt = 1'b1;
                    state_nxt = ABORT;
                end else if (bus.div_ready_i) begin
                    hi_nxt    = bus.div_result_i[63:32];
                    lo_nxt    = bus.div_result_i[31:0];
                    we_nxt    = 1'b1;
                    start_nxt = 1'b0;
                    state_nxt = DONE;
                end else if (cnt == LAST_CNT) begin
                    start_nxt = 1'b0;
                    annul_nxt = 1'b1;
                    err_nxt   = 1'b1;
                    state_nxt = ABORT;
                end else begin
                    cnt_nxt = cnt + 6'd1;
                end
            end
            DONE: begin
                start_nxt = 1'b0;
                state_nxt = IDLE;
            end
            ABORT: begin
                start_nxt = 1'b0;
                state_nxt = IDLE;
            end
            default: begin
                start_nxt = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    // Outside RUN a stall is only needed for a pending divide; reset masks it entirely.
    assign bus.stallreq_o   = !rst && !bus.flush_i && ((state == RUN) || bus.ex_div_i);

    assign bus.div_signed_o = signed_q;
    assign bus.div_op1_o    = op1_q;
    assign bus.div_op2_o    = op2_q;
    assign bus.div_start_o  = start_q;
    assign bus.div_annul_o  = annul_q;
    assign bus.hilo_we_o    = we_q;
    assign bus.hi_o         = hi_q;
    assign bus.lo_o         = lo_q;
    assign bus.err_o        = err_q;
endmodule

// File: tb/tb_div_ctrl.sv
// Directed plus randomized bench for div_ctrl; a behavioural divider and outcome model
// predict every cycle of each operation.
module tb_div_ctrl;
    localparam int TIMEOUT = 40;
    localparam int NEVER   = 100000;

    logic clk = 1'b0;
    logic rst;
    div_ctrl_if bus ();

    div_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_regs(input string tag, input logic st, input logic an,
                            input logic we, input logic er);
        chk({tag, ".start"}, 64'(bus.div_start_o), 64'(st));
        chk({tag, ".annul"}, 64'(bus.div_annul_o), 64'(an));
        chk({tag, ".hilo_we"}, 64'(bus.hilo_we_o), 64'(we));
        chk({tag, ".err"}, 64'(bus.err_o), 64'(er));
        chk({tag, ".hi"}, 64'(bus.hi_o), 64'(exp_hi));
        chk({tag, ".lo"}, 64'(bus.lo_o), 64'(exp_lo));
    endtask

    // Reference divider: {remainder, quotient}; divide-by-zero returns {dividend, all ones}.
    function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a,
                                            input logic [31:0] b);
        int sa, sb, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (sgn) begin
            sa = $signed(a);
            sb = $signed(b);
            q  = sa / sb;
            r  = sa % sb;
            return {32'(r), 32'(q)};
        end
        return {a % b, a / b};
    endfunction

    // One divide from its request cycle (T0, controller in IDLE) until the following IDLE cycle.
    // lat: RUN cycle in which the divider raises ready (0 = never); flush_at / rst_at likewise.
    task automatic do_op(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input int flush_at, input int rst_at,
                         input bit next_req);
        logic [63:0] res;
        int f, l, rr, n_run;
        res   = ref_div(sgn, a, b);
        f     = (flush_at > 0) ? flush_at : NEVER;
        l     = (lat > 0) ? lat : NEVER;
        rr    = (rst_at > 0) ? rst_at : NEVER;
        n_run = TIMEOUT;
        if (f < n_run) n_run = f;
        if (l < n_run) n_run = l;
        if (rr < n_run) n_run = rr;

        bus.ex_div_i    = 1'b1;
        bus.ex_signed_i = sgn;
        bus.ex_op1_i    = a;
        bus.ex_op2_i    = b;
        bus.flush_i     = 1'b0;
        bus.div_ready_i = 1'b0;
        #1;
        chk("t0.stallreq", 64'(bus.stallreq_o), 64'd1);

        for (int i = 1; i <= n_run; i++) begin
            step();
            chk_regs("run", 1'b1, 1'b0, 1'b0, 1'b0);
            chk("run.signed", 64'(bus.div_signed_o), 64'(sgn));
            chk("run.op1", 64'(bus.div_op1_o), 64'(a));
            chk("run.op2", 64'(bus.div_op2_o), 64'(b));
            bus.ex_op1_i     = $urandom;
            bus.ex_op2_i     = $urandom;
            bus.div_ready_i  = (i == lat);
            bus.div_result_i = (i == lat) ? res : {$urandom, $urandom};
            bus.flush_i      = (i == flush_at);
            rst              = (i == rst_at);
            #1;
            chk("run.stallreq", 64'(bus.stallreq_o),
                64'((i != rst_at) && (i != flush_at)));
        end

        if (rr == n_run && rr < f && rr < l && rr <= TIMEOUT) begin
            step();
            exp_hi = '0;
            exp_lo = '0;
            chk_regs("rst_mid", 1'b0, 1'b0, 1'b0, 1'b0);
            chk("rst_mid.signed", 64'(bus.div_signed_o), 64'd0);
            chk("rst_mid.op1", 64'(bus.div_op1_o), 64'd0);
            chk("rst_mid.op2", 64'(bus.div_op2_o), 64'd0);
            chk("rst_mid.stallreq", 64'(bus.stallreq_o), 64'd0);
            rst             = 1'b0;
            bus.ex_div_i    = 1'b0;
            bus.div_ready_i = 1'b0;
            #1;
            chk("rst_mid.idle_stall", 64'(bus.stallreq_o), 64'd0);
            step();
            chk_regs("rst_mid.idle", 1'b0, 1'b0, 1'b0, 1'b0);
            return;
        end

        step();
        if (f == n_run) begin
            chk_regs("flush", 1'b0, 1'b1, 1'b0, 1'b0);
        end else if (l == n_run) begin
            exp_hi = res[63:32];
            exp_lo = res[31:0];
            chk_regs("done", 1'b0, 1'b0, 1'b1, 1'b0);
        end else begin
            chk_regs("timeout", 1'b0, 1'b1, 1'b0, 1'b1);
        end
        bus.div_ready_i  = 1'b0;
        bus.div_result_i = {$urandom, $urandom};
        bus.flush_i      = 1'b0;
        bus.ex_div_i     = next_req;
        #1;
        chk("post.stallreq", 64'(bus.stallreq_o), 64'(next_req));

        step();
        chk_regs("idle", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("idle.stallreq", 64'(bus.stallreq_o), 64'(next_req));
    endtask

    initial begin
        bit          sgn, nreq;
        logic [31:0] a, b;
        int          lat, fl;

        rst              = 1'b1;
        bus.ex_div_i     = 1'b1;
        bus.ex_signed_i  = 1'b1;
        bus.ex_op1_i     = 32'h1234_5678;
        bus.ex_op2_i     = 32'h0000_0003;
        bus.flush_i      = 1'b0;
        bus.div_result_i = '0;
        bus.div_ready_i  = 1'b0;

        repeat (3) begin
            step();
            chk_regs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
            chk("reset.signed", 64'(bus.div_signed_o), 64'd0);
            chk("reset.op1", 64'(bus.div_op1_o), 64'd0);
            chk("reset.op2", 64'(bus.div_op2_o), 64'd0);
            chk("reset.stallreq", 64'(bus.stallreq_o), 64'd0);
        end
        rst = 1'b0;

        do_op(1'b0, 32'd100, 32'd7, 34, 0, 0, 1'b0);
        chk("divu.hi", 64'(exp_hi), 64'd2);
        chk("divu.lo", 64'(exp_lo), 64'd14);

        do_op(1'b1, 32'hFFFF_FF9C, 32'd7, 20, 0, 0, 1'b0);
        chk("div.hi", 64'(bus.hi_o), 64'hFFFF_FFFE);
        chk("div.lo", 64'(bus.lo_o), 64'hFFFF_FFF2);

        // Request under flush in IDLE is ignored.
        bus.ex_div_i = 1'b1;
        bus.flush_i  = 1'b1;
        #1;
        chk("idle_flush.stallreq", 64'(bus.stallreq_o), 64'd0);
        step();
        chk_regs("idle_flush", 1'b0, 1'b0, 1'b0, 1'b0);
        bus.flush_i  = 1'b0;
        bus.ex_div_i = 1'b0;
        step();

        do_op(1'b0, 32'd1234, 32'd5, 30, 10, 0, 1'b0);
        do_op(1'b1, 32'd77, 32'd3, 0, 0, 0, 1'b0);
        do_op(1'b0, 32'd50, 32'd6, TIMEOUT, 0, 0, 1'b0);
        do_op(1'b0, 32'd50, 32'd6, TIMEOUT + 1, 0, 0, 1'b0);
        do_op(1'b0, 32'd10, 32'd3, 5, 5, 0, 1'b0);
        do_op(1'b0, 32'd10, 32'd0, 3, 0, 0, 1'b0);

        for (int n = 0; n < 10; n++) begin
            sgn = 1'($urandom);
            a   = $urandom;
            b   = $urandom >> $urandom_range(0, 31);
            if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd2;
            lat  = $urandom_range(0, 45);
            fl   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 45) : 0;
            nreq = 1'($urandom);
            do_op(sgn, a, b, lat, fl, 0, nreq);
        end

        do_op(1'b0, 32'd8, 32'd2, 6, 0, 0, 1'b1);
        chk("b2b1.hi", 64'(bus.hi_o), 64'd0);
        chk("b2b1.lo", 64'(bus.lo_o), 64'd4);
        do_op(1'b0, 32'd9, 32'd4, 6, 0, 0, 1'b1);
        chk("b2b2.hi", 64'(bus.hi_o), 64'd1);
        chk("b2b2.lo", 64'(bus.lo_o), 64'd2);
        do_op(1'b0, 32'd9, 32'd4, 0, 0, 7, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
